// File: rtl/trc_pkg.sv
// Shared definitions for the test run controller: FSM state encoding,
// the tohost exit code that means "pass", and the full-word byte enable.
package trc_pkg;

  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_RESET = 2'd1,
    TRC_RUN   = 2'd2,
    TRC_DONE  = 2'd3
  } trc_state_e;

  localparam int unsigned TRC_PASS_CODE = 1;
  localparam logic [3:0]  TRC_BE_FULL   = 4'b1111;

endpackage

// File: rtl/trc_sig_buffer.sv
// Signature capture buffer: SIG_DEPTH words of DATAWIDTH bits, written per
// enabled byte, cleared synchronously, read combinationally.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (clears the array)
//   clr          synchronous clear of the whole array
//   wr_en        write strobe; wr_idx/wr_data/wr_be give word, data, bytes
//   rd_idx       read index; indices >= SIG_DEPTH read as zero
//   rd_data      combinational read data
module trc_sig_buffer
  import trc_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned SIG_DEPTH = 8,
  parameter int unsigned AW        = (SIG_DEPTH > 1) ? $clog2(SIG_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_idx,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic [3:0]           wr_be,
  input  logic [AW:0]          rd_idx,
  output logic [DATAWIDTH-1:0] rd_data
);

  logic [DATAWIDTH-1:0] mem_q [SIG_DEPTH];
  logic [DATAWIDTH-1:0] mem_d [SIG_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '{default: '0};
    end else if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // The index port is one bit wider than the array address so that
  // out-of-range requests can be detected and zeroed.
  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < SIG_DEPTH) begin
      rd_data = mem_q[rd_idx[AW-1:0]];
    end
  end

endmodule

// File: rtl/test_run_controller.sv
// Run controller between the clock/reset source and the core + memories.
// Sequences the core reset, counts RUN cycles and instruction fetches,
// snoops data-memory writes for the tohost mailbox (with a cycle timeout)
// and captures writes into the signature region.
// Ports:
//   TRC_Clk_in, TRC_Reset_in       clock, synchronous active-low reset
//   TRC_Start_in                   start/restart (honoured in IDLE/DONE)
//   TRC_Insmem_Read_in             core instruction-fetch strobe
//   TRC_Datamem_*                  core data-memory write snoop
//   TRC_Sig_Index_InBUS            signature read index
//   TRC_Core_Reset_out             active-low reset to the core
//   TRC_Done/Pass/Timeout_out      run outcome flags
//   TRC_Exitcode_OutBUS            value written to tohost
//   TRC_Cycles/Fetches_OutBUS      RUN cycle and fetch counts
//   TRC_Sig_Data/Count_OutBUS      signature read data, accepted-write count
module test_run_controller
  import trc_pkg::*;
#(
  parameter int unsigned          DATAWIDTH      = 32,
  parameter int unsigned          CNT_WIDTH      = 32,
  parameter int unsigned          RESET_CYCLES   = 4,
  parameter int unsigned          TIMEOUT_CYCLES = 150,
  parameter logic [DATAWIDTH-1:0] TOHOST_ADDR    = 32'h0000_03FC,
  parameter logic [DATAWIDTH-1:0] SIG_BASE       = 32'h0000_0200,
  parameter int unsigned          SIG_DEPTH      = 8
) (
  input  logic                        TRC_Clk_in,
  input  logic                        TRC_Reset_in,
  input  logic                        TRC_Start_in,
  input  logic                        TRC_Insmem_Read_in,
  input  logic                        TRC_Datamem_Write_in,
  input  logic [DATAWIDTH-1:0]        TRC_Datamem_Addr_InBUS,
  input  logic [DATAWIDTH-1:0]        TRC_Datamem_Writedata_InBUS,
  input  logic [3:0]                  TRC_Datamem_Byteenable_InBUS,
  input  logic [$clog2(SIG_DEPTH):0]  TRC_Sig_Index_InBUS,
  output logic                        TRC_Core_Reset_out,
  output logic                        TRC_Done_out,
  output logic                        TRC_Pass_out,
  output logic                        TRC_Timeout_out,
  output logic [DATAWIDTH-1:0]        TRC_Exitcode_OutBUS,
  output logic [CNT_WIDTH-1:0]        TRC_Cycles_OutBUS,
  output logic [CNT_WIDTH-1:0]        TRC_Fetches_OutBUS,
  output logic [DATAWIDTH-1:0]        TRC_Sig_Data_OutBUS,
  output logic [$clog2(SIG_DEPTH):0]  TRC_Sig_Count_OutBUS
);

  localparam int unsigned          SIG_AW   = (SIG_DEPTH > 1) ? $clog2(SIG_DEPTH) : 1;
  localparam int unsigned          SC_W     = $clog2(SIG_DEPTH) + 1;
  localparam int unsigned          RC_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]      RST_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [SC_W-1:0]      SIG_FULL = SC_W'(SIG_DEPTH);
  localparam logic [DATAWIDTH-1:0] SIG_END  = SIG_BASE + DATAWIDTH'(4 * SIG_DEPTH);

  trc_state_e           state_q, state_d;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic                 core_rst_q, core_rst_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 tmo_q, tmo_d;
  logic [DATAWIDTH-1:0] exit_q, exit_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0] fetches_q, fetches_d;
  logic [SC_W-1:0]      sig_cnt_q, sig_cnt_d;

  logic                 in_run, tohost_hit, sig_hit, sig_clr;
  logic [DATAWIDTH-1:0] sig_off;
  logic [SIG_AW-1:0]    sig_idx;

  assign in_run     = (state_q == TRC_RUN);
  assign tohost_hit = in_run && TRC_Datamem_Write_in
                      && (TRC_Datamem_Addr_InBUS == TOHOST_ADDR)
                      && (TRC_Datamem_Byteenable_InBUS == TRC_BE_FULL);
  assign sig_hit    = in_run && TRC_Datamem_Write_in
                      && (TRC_Datamem_Addr_InBUS[1:0] == 2'b00)
                      && (TRC_Datamem_Addr_InBUS >= SIG_BASE)
                      && (TRC_Datamem_Addr_InBUS < SIG_END);
  assign sig_off    = TRC_Datamem_Addr_InBUS - SIG_BASE;
  assign sig_idx    = SIG_AW'(sig_off >> 2);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    core_rst_d = core_rst_q;
    done_d    = done_q;
    pass_d    = pass_q;
    tmo_d     = tmo_q;
    exit_d    = exit_q;
    cycles_d  = cycles_q;
    fetches_d = fetches_q;
    sig_cnt_d = sig_cnt_q;
    sig_clr   = 1'b0;
    unique case (state_q)
      TRC_IDLE, TRC_DONE: begin
        if (TRC_Start_in) begin
          state_d    = TRC_RESET;
          rst_cnt_d  = '0;
          core_rst_d = 1'b0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          tmo_d      = 1'b0;
          exit_d     = '0;
          cycles_d   = '0;
          fetches_d  = '0;
          sig_cnt_d  = '0;
          sig_clr    = 1'b1;
        end
      end
      TRC_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d    = TRC_RUN;
          core_rst_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      TRC_RUN: begin
        cycles_d = cycles_q + 1'b1;
        if (TRC_Insmem_Read_in && (fetches_q != '1)) begin
          fetches_d = fetches_q + 1'b1;
        end
        if (sig_hit && (sig_cnt_q != SIG_FULL)) begin
          sig_cnt_d = sig_cnt_q + 1'b1;
        end
        // A tohost write on the final timeout edge takes precedence.
        if (tohost_hit) begin
          state_d    = TRC_DONE;
          core_rst_d = 1'b0;
          done_d     = 1'b1;
          exit_d     = TRC_Datamem_Writedata_InBUS;
          pass_d     = (TRC_Datamem_Writedata_InBUS == DATAWIDTH'(TRC_PASS_CODE));
          tmo_d      = 1'b0;
        end else if (cycles_q == TMO_LAST) begin
          state_d    = TRC_DONE;
          core_rst_d = 1'b0;
          done_d     = 1'b1;
          exit_d     = '0;
          pass_d     = 1'b0;
          tmo_d      = 1'b1;
        end
      end
      default: state_d = TRC_IDLE;
    endcase
  end

  always_ff @(posedge TRC_Clk_in) begin
    if (!TRC_Reset_in) begin
      state_q    <= TRC_IDLE;
      rst_cnt_q  <= '0;
      core_rst_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      exit_q     <= '0;
      cycles_q   <= '0;
      fetches_q  <= '0;
      sig_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      exit_q     <= exit_d;
      cycles_q   <= cycles_d;
      fetches_q  <= fetches_d;
      sig_cnt_q  <= sig_cnt_d;
    end
  end

  trc_sig_buffer #(
    .DATAWIDTH (DATAWIDTH),
    .SIG_DEPTH (SIG_DEPTH),
    .AW        (SIG_AW)
  ) u_sig_buffer (
    .clk     (TRC_Clk_in),
    .rst_n   (TRC_Reset_in),
    .clr     (sig_clr),
    .wr_en   (sig_hit),
    .wr_idx  (sig_idx),
    .wr_data (TRC_Datamem_Writedata_InBUS),
    .wr_be   (TRC_Datamem_Byteenable_InBUS),
    .rd_idx  (TRC_Sig_Index_InBUS),
    .rd_data (TRC_Sig_Data_OutBUS)
  );

  assign TRC_Core_Reset_out   = core_rst_q;
  assign TRC_Done_out         = done_q;
  assign TRC_Pass_out         = pass_q;
  assign TRC_Timeout_out      = tmo_q;
  assign TRC_Exitcode_OutBUS  = exit_q;
  assign TRC_Cycles_OutBUS    = cycles_q;
  assign TRC_Fetches_OutBUS   = fetches_q;
  assign TRC_Sig_Count_OutBUS = sig_cnt_q;

endmodule

// File: doc/test_run_controller.md
Name: test_run_controller

Overview:
- Parametrised run controller that sits between a simulation clock/reset source and the CORE / INS_MEM / DATAMEM trio.
- Generates the core reset sequence and counts run cycles and instruction fetches.
- Snoops data-memory writes for an end-of-test "tohost" write, with a configurable timeout.
- Captures a byte-enabled signature region into an internal buffer.
- Replaces fixed-length "wait N clocks then stop" runs with a deterministic Done/Pass/Timeout outcome.

Parameters:
- DATAWIDTH, 32: data and address bus width.
- CNT_WIDTH, 32: width of the cycle and fetch counters.
- RESET_CYCLES, 4: number of cycles the core reset is held low after Start; must be >= 1.
- TIMEOUT_CYCLES, 150: maximum number of RUN cycles before a forced finish; must be >= 1.
- TOHOST_ADDR, 32'h000003FC: end-of-test mailbox word address.
- SIG_BASE, 32'h00000200: signature region base address; word aligned.
- SIG_DEPTH, 8: number of signature words; power of two.

Ports:
- TRC_Clk_in  in  1  single clock.
- TRC_Reset_in  in  1  synchronous, active-low reset.
- TRC_Start_in  in  1  start/restart request; sampled in IDLE and DONE only.
- TRC_Insmem_Read_in  in  1  core instruction-fetch strobe.
- TRC_Datamem_Write_in  in  1  core data-memory write strobe.
- TRC_Datamem_Addr_InBUS  in  DATAWIDTH  data-memory write address.
- TRC_Datamem_Writedata_InBUS  in  DATAWIDTH  data-memory write data.
- TRC_Datamem_Byteenable_InBUS  in  4  byte enables.
- TRC_Sig_Index_InBUS  in  $clog2(SIG_DEPTH)+1  signature read index.
- TRC_Core_Reset_out  out  1  active-low reset driven to the core.
- TRC_Done_out  out  1  run finished.
- TRC_Pass_out  out  1  run passed.
- TRC_Timeout_out  out  1  run ended by timeout.
- TRC_Exitcode_OutBUS  out  DATAWIDTH  value written to tohost.
- TRC_Cycles_OutBUS  out  CNT_WIDTH  RUN cycle count.
- TRC_Fetches_OutBUS  out  CNT_WIDTH  instruction-fetch count.
- TRC_Sig_Data_OutBUS  out  DATAWIDTH  signature word at the requested index.
- TRC_Sig_Count_OutBUS  out  $clog2(SIG_DEPTH)+1  number of accepted signature writes, saturating.

Behaviour:
- Reset: TRC_Reset_in=0 at a posedge forces IDLE.
  - All outputs become 0, including TRC_Core_Reset_out.
  - Counters and the whole signature array are cleared.
  - Applies mid-run too: the run is aborted with no Done.
- FSM states: IDLE, RESET, RUN, DONE. All outputs are registered except TRC_Sig_Data_OutBUS.
- IDLE: TRC_Core_Reset_out=0.
  - Start=1 -> RESET.
  - On that same edge, clear the cycle, fetch and signature counts, the signature array, Done, Pass, Timeout and Exitcode.
- RESET: TRC_Core_Reset_out=0 for exactly RESET_CYCLES cycles.
  - TRC_Core_Reset_out rises to 1 at edge k+RESET_CYCLES, where k is the Start edge; state -> RUN at that edge.
- RUN: TRC_Core_Reset_out=1.
  - Cycle counter increments by 1 at each RUN edge; the first RUN edge gives 1.
  - Fetch counter increments when TRC_Insmem_Read_in=1.
  - Start is ignored.
- Tohost: Write=1, Addr==TOHOST_ADDR and Byteenable==4'b1111 -> DONE at the next edge.
  - Exitcode=Writedata; Pass=(Writedata==1); Timeout=0.
  - Partial-byte writes to tohost are ignored.
- Timeout: the edge at which the cycle count reaches TIMEOUT_CYCLES -> DONE, Timeout=1, Pass=0, Exitcode=0.
  - If a valid tohost write occurs on that same edge, tohost wins: Timeout=0.
- DONE: Done=1, TRC_Core_Reset_out=0 (core frozen); counters and results hold.
  - Start=1 -> RESET with the same clears as from IDLE.
- Signature capture (RUN only): Write=1, Addr[1:0]==0 and SIG_BASE <= Addr < SIG_BASE+4*SIG_DEPTH.
  - Entry index (Addr-SIG_BASE)>>2 is updated per enabled byte.
  - Sig_Count increments by 1 and saturates at SIG_DEPTH.
  - Misaligned or out-of-region writes are ignored.
  - A tohost write that also falls in the region is captured too.
- Signature read: combinational on TRC_Sig_Index_InBUS; an index >= SIG_DEPTH returns 0.
- Counters do not wrap: the cycle count is bounded by the timeout, and the fetch count saturates at all-ones.

Decomposition:
- Package trc_pkg holds:
  - State encodings (IDLE/RESET/RUN/DONE).
  - TRC_PASS_CODE = 1.
  - TRC_BE_FULL = 4'b1111.
- Sub-module trc_sig_buffer:
  - SIG_DEPTH x DATAWIDTH byte-enabled register array.
  - Synchronous clear, write port, combinational read port with out-of-range zeroing.
- FSM and counters stay in the top module.

Test Plan:
- Reset/start: Reset low 2 cycles -> all outputs 0. Start pulse at edge k (RESET_CYCLES=4) -> Core_Reset_out=0 through edge k+3, 1 at edge k+4.
- Pass: 10 RUN cycles then write 0x00000001 to 0x3FC with BE 1111 -> next edge Done=1, Pass=1, Timeout=0, Exitcode=1, Cycles=11, Core_Reset_out=0. Fetches equals the number of Insmem_Read cycles driven.
- Fail and partial: write 0x1 with BE 0011 to 0x3FC -> no Done. Then write 0x7 with BE 1111 -> Done=1, Pass=0, Exitcode=7.
- Timeout: TIMEOUT_CYCLES=20, no tohost write -> Done=1, Timeout=1, Cycles=20. Repeat with the tohost write of 1 on the 20th edge -> Pass=1, Timeout=0.
- Signature: write 0xAABBCCDD to 0x204 (BE 1111), then 0x00000011 to 0x204 (BE 0001) -> index 1 reads 0xAABBCC11, Sig_Count=2.
  - A write to 0x206 is ignored.
  - Index 9 reads 0.
  - 10 valid writes -> Sig_Count=8.
- Abort/restart: Reset low during RUN -> IDLE, counters 0, signature reads 0, Done=0. Start in RUN is ignored. Start in DONE -> RESET, counters cleared, new run completes.
